// File: rtl/mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the byte-serial memory arbiter:
//   - controller state and request-source encodings
//   - access size codes (byte / half / word) and a size-to-byte-count helper
//   - default width of the ROB tag carried with loads
// ----------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int ROB_SIZE_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SRC_IC  = 2'd0,
        SRC_LSB = 2'd1,
        SRC_ROB = 2'd2
    } src_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Number of bytes moved for a size code; the unused code is treated as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_extend.sv
// ----------------------------------------------------------------------------
// mem_extend
// Combinational size/sign extension of an assembled little-endian word.
//   raw       in  32  assembled read data (lane 0 = lowest address)
//   size      in   2  SZ_B / SZ_H / SZ_W
//   is_signed in   1  1 = sign-extend byte/half, 0 = zero-extend
//   data      out 32  extended result
// ----------------------------------------------------------------------------
module mem_extend
    import mem_arbiter_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] data
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        data = raw;
        case (size)
            SZ_B:    data = {{24{is_signed & raw[7]}},  raw[7:0]};
            SZ_H:    data = {{16{is_signed & raw[15]}}, raw[15:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
// Byte-serial memory controller between the instruction cache, load/store
// buffer and reorder buffer and an 8-bit RAM/UART port. One request is served
// at a time; reads are assembled little-endian and extended, writes stall on
// a full I/O buffer, and each requester gets a one-cycle completion pulse.
//
// Ports:
//   clk_in, rst_n_in            clock, async active-low reset
//   rdy_in                      global enable (low freezes everything)
//   clear_in                    flush: aborts reads/fetches, never writes
//   io_buffer_full              UART buffer full, stalls I/O writes
//   byte_dout / byte_din        RAM read data (1-cycle latency) / write data
//   byte_a / byte_wr            RAM byte address / write strobe
//   ic_valid, ic_addr           word fetch request
//   lsb_valid .. lsb_rob_id     load request (size, signedness, ROB tag)
//   rob_valid .. rob_size       store request
//   iout_ready, iout            fetch done pulse + instruction
//   dout_ready, dout, dout_rob_id  load done pulse + extended data + tag
//   wdone                       store done pulse
// ----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ROB_W       = ROB_SIZE_WIDTH,
    parameter int IO_ADDR_BIT = 17
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             clear_in,
    input  logic             io_buffer_full,
    input  logic [7:0]       byte_dout,
    output logic [7:0]       byte_din,
    output logic [31:0]      byte_a,
    output logic             byte_wr,
    input  logic             ic_valid,
    input  logic [31:0]      ic_addr,
    input  logic             lsb_valid,
    input  logic [31:0]      lsb_addr,
    input  logic [1:0]       lsb_size,
    input  logic             lsb_signed,
    input  logic [ROB_W-1:0] lsb_rob_id,
    input  logic             rob_valid,
    input  logic [31:0]      rob_addr,
    input  logic [31:0]      rob_data,
    input  logic [1:0]       rob_size,
    output logic             iout_ready,
    output logic [31:0]      iout,
    output logic             dout_ready,
    output logic [31:0]      dout,
    output logic [ROB_W-1:0] dout_rob_id,
    output logic             wdone
);

    state_t           state;
    src_t             src;
    logic [2:0]       byte_cnt;
    logic [31:0]      base;
    logic [31:0]      wdata;
    logic [31:0]      rbuf;
    logic [1:0]       size;
    logic             sgn;
    logic [ROB_W-1:0] tag;
    logic             last_data;   // 1 = last grant was a load or store
    logic             iout_q, dout_q, wdone_q;

    logic [2:0]  n;
    logic [31:0] cur_addr;
    logic        io_stall;
    logic [1:0]  lane;
    logic [31:0] rnext;
    logic [31:0] ext;
    logic        fetch_pick;

    assign n        = size_bytes(size);
    assign cur_addr = base + {29'd0, byte_cnt};
    assign io_stall = (cur_addr[IO_ADDR_BIT -: 2] == 2'b11) && io_buffer_full;

    // Read data for address k arrives while byte_cnt == k+1, so it lands in lane byte_cnt-1.
    assign lane = byte_cnt[1:0] - 2'd1;

    always_comb begin
        rnext = rbuf;
        if (byte_cnt != 3'd0) rnext[{lane, 3'b000} +: 8] = byte_dout;
    end

    mem_extend u_extend (
        .raw       (rnext),
        .size      (size),
        .is_signed (sgn),
        .data      (ext)
    );

    // Store wins outright; otherwise fetch wins a tie only after a data grant.
    assign fetch_pick = ic_valid && (!lsb_valid || last_data);

    // RAM port is driven straight from the registered state so that an async
    // reset drops byte_wr/byte_a immediately.
    always_comb begin
        byte_a   = '0;
        byte_din = '0;
        byte_wr  = 1'b0;
        if (state == ST_READ) begin
            byte_a = cur_addr;
        end else if (state == ST_WRITE) begin
            byte_a   = cur_addr;
            byte_din = wdata[{byte_cnt[1:0], 3'b000} +: 8];
            byte_wr  = rdy_in && !io_stall;
        end
    end

    // A flush during the DONE cycle of a read hides its pulse; stores always report.
    assign iout_ready = iout_q && !clear_in;
    assign dout_ready = dout_q && !clear_in;
    assign wdone      = wdone_q;

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= ST_IDLE;
            src         <= SRC_IC;
            byte_cnt    <= '0;
            base        <= '0;
            wdata       <= '0;
            rbuf        <= '0;
            size        <= SZ_W;
            sgn         <= 1'b0;
            tag         <= '0;
            last_data   <= 1'b0;
            iout        <= '0;
            dout        <= '0;
            dout_rob_id <= '0;
            iout_q      <= 1'b0;
            dout_q      <= 1'b0;
            wdone_q     <= 1'b0;
        end else if (rdy_in) begin
            iout_q  <= 1'b0;
            dout_q  <= 1'b0;
            wdone_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    byte_cnt <= '0;
                    rbuf     <= '0;
                    if (!clear_in) begin
                        if (rob_valid) begin
                            src       <= SRC_ROB;
                            base      <= rob_addr;
                            size      <= rob_size;
                            wdata     <= rob_data;
                            sgn       <= 1'b0;
                            last_data <= 1'b1;
                            state     <= ST_WRITE;
                        end else if (fetch_pick) begin
                            src       <= SRC_IC;
                            base      <= ic_addr;
                            size      <= SZ_W;
                            sgn       <= 1'b0;
                            last_data <= 1'b0;
                            state     <= ST_READ;
                        end else if (lsb_valid) begin
                            src       <= SRC_LSB;
                            base      <= lsb_addr;
                            size      <= lsb_size;
                            sgn       <= lsb_signed;
                            tag       <= lsb_rob_id;
                            last_data <= 1'b1;
                            state     <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (clear_in) begin
                        state <= ST_IDLE;
                    end else begin
                        rbuf <= rnext;
                        if (byte_cnt == n) begin
                            state <= ST_DONE;
                            if (src == SRC_IC) begin
                                iout   <= ext;
                                iout_q <= 1'b1;
                            end else begin
                                dout        <= ext;
                                dout_rob_id <= tag;
                                dout_q      <= 1'b1;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (!io_stall) begin
                        if (byte_cnt == n - 3'd1) begin
                            state   <= ST_DONE;
                            wdone_q <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with a small byte RAM model (1-cycle read
// latency) that logs every write as {address, data}.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        clear_in;
    logic        io_buffer_full;
    logic [7:0]  byte_dout;
    logic [7:0]  byte_din;
    logic [31:0] byte_a;
    logic        byte_wr;
    logic        ic_valid;
    logic [31:0] ic_addr;
    logic        lsb_valid;
    logic [31:0] lsb_addr;
    logic [1:0]  lsb_size;
    logic        lsb_signed;
    logic [3:0]  lsb_rob_id;
    logic        rob_valid;
    logic [31:0] rob_addr;
    logic [31:0] rob_data;
    logic [1:0]  rob_size;
    logic        iout_ready;
    logic [31:0] iout;
    logic        dout_ready;
    logic [31:0] dout;
    logic [3:0]  dout_rob_id;
    logic        wdone;

    int checks = 0;
    int errors = 0;

    mem_arbiter dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .rdy_in         (rdy_in),
        .clear_in       (clear_in),
        .io_buffer_full (io_buffer_full),
        .byte_dout      (byte_dout),
        .byte_din       (byte_din),
        .byte_a         (byte_a),
        .byte_wr        (byte_wr),
        .ic_valid       (ic_valid),
        .ic_addr        (ic_addr),
        .lsb_valid      (lsb_valid),
        .lsb_addr       (lsb_addr),
        .lsb_size       (lsb_size),
        .lsb_signed     (lsb_signed),
        .lsb_rob_id     (lsb_rob_id),
        .rob_valid      (rob_valid),
        .rob_addr       (rob_addr),
        .rob_data       (rob_data),
        .rob_size       (rob_size),
        .iout_ready     (iout_ready),
        .iout           (iout),
        .dout_ready     (dout_ready),
        .dout           (dout),
        .dout_rob_id    (dout_rob_id),
        .wdone          (wdone)
    );

    always #5 clk_in = ~clk_in;

    // RAM model: the always block is the only writer of mem and wlog.
    logic [7:0]  mem [0:4095];
    logic [39:0] wlog [$];
    logic        pre_we = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;

    always @(posedge clk_in) begin
        byte_dout <= mem[byte_a[11:0]];
        if (pre_we) mem[pre_addr] = pre_data;
        if (byte_wr) begin
            mem[byte_a[11:0]] = byte_din;
            wlog.push_back({byte_a, byte_din});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(posedge clk_in);
        #1;
        pre_we   = 1'b0;
    endtask

    // Counts falling edges until any done pulse is seen (bounded by limit).
    task automatic wait_done(input int limit, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk_in);
            cycles++;
        end while (!(iout_ready || dout_ready || wdone) && cycles < limit);
    endtask

    initial begin
        int c;
        int w0;
        int seen;

        rst_n_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0; io_buffer_full = 1'b0;
        ic_valid = 1'b0; ic_addr = '0;
        lsb_valid = 1'b0; lsb_addr = '0; lsb_size = 2'd0; lsb_signed = 1'b0; lsb_rob_id = '0;
        rob_valid = 1'b0; rob_addr = '0; rob_data = '0; rob_size = 2'd0;

        preload(12'h100, 8'h11); preload(12'h101, 8'h22);
        preload(12'h102, 8'h33); preload(12'h103, 8'h44);
        preload(12'h150, 8'h80);
        preload(12'h160, 8'h01); preload(12'h161, 8'h80);

        @(negedge clk_in);
        check("reset_ready", {iout_ready, dout_ready, wdone}, 0);
        check("reset_port", {byte_wr, byte_a}, 0);
        check("reset_data", {iout, dout}, 0);
        check("reset_tag", dout_rob_id, 0);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        // Word fetch at 0x100.
        w0 = wlog.size();
        ic_valid = 1'b1; ic_addr = 32'h100;
        wait_done(20, c);
        check("fetch_latency", c, 6);
        check("fetch_pulse", {iout_ready, dout_ready, wdone}, 3'b100);
        check("fetch_iout", iout, 32'h44332211);
        check("fetch_no_write", wlog.size() - w0, 0);
        ic_valid = 1'b0;
        @(negedge clk_in);
        check("fetch_pulse_gone", iout_ready, 0);

        // Signed byte load of 0x80, tag 3.
        lsb_valid = 1'b1; lsb_addr = 32'h150; lsb_size = 2'd0; lsb_signed = 1'b1; lsb_rob_id = 4'd3;
        wait_done(20, c);
        check("lb_latency", c, 3);
        check("lb_dout", dout, 32'hFFFFFF80);
        check("lb_tag", dout_rob_id, 4'd3);
        lsb_valid = 1'b0;
        @(negedge clk_in);

        // Same load unsigned.
        lsb_valid = 1'b1; lsb_signed = 1'b0; lsb_rob_id = 4'd5;
        wait_done(20, c);
        check("lbu_dout", {dout_ready, dout}, {1'b1, 32'h00000080});
        lsb_valid = 1'b0;
        @(negedge clk_in);

        // Signed half load of 0x8001.
        lsb_valid = 1'b1; lsb_addr = 32'h160; lsb_size = 2'd1; lsb_signed = 1'b1; lsb_rob_id = 4'd9;
        wait_done(20, c);
        check("lh_latency", c, 4);
        check("lh_dout", dout, 32'hFFFF8001);
        lsb_valid = 1'b0;
        @(negedge clk_in);

        // Half store 0xBEEF at 0x200.
        w0 = wlog.size();
        rob_valid = 1'b1; rob_addr = 32'h200; rob_data = 32'h0000BEEF; rob_size = 2'd1;
        wait_done(20, c);
        check("sh_latency", c, 3);
        check("sh_wdone", wdone, 1);
        check("sh_count", wlog.size() - w0, 2);
        check("sh_byte0", wlog[w0], {32'h200, 8'hEF});
        check("sh_byte1", wlog[w0 + 1], {32'h201, 8'hBE});
        rob_valid = 1'b0;
        @(negedge clk_in);

        // All three requesters at once: store, then fetch, then load.
        rob_valid = 1'b1; rob_addr = 32'h210; rob_data = 32'h5A; rob_size = 2'd0;
        ic_valid = 1'b1; ic_addr = 32'h100;
        lsb_valid = 1'b1; lsb_addr = 32'h150; lsb_size = 2'd0; lsb_signed = 1'b0; lsb_rob_id = 4'd7;
        wait_done(20, c);
        check("arb1_store", {c[3:0], iout_ready, dout_ready, wdone}, {4'd2, 3'b001});
        rob_valid = 1'b0;
        wait_done(20, c);
        check("arb2_fetch", {c[3:0], iout_ready, dout_ready, wdone}, {4'd7, 3'b100});
        check("arb2_iout", iout, 32'h44332211);
        ic_valid = 1'b0;
        wait_done(20, c);
        check("arb3_load", {c[3:0], iout_ready, dout_ready, wdone}, {4'd4, 3'b010});
        check("arb3_dout", {dout_rob_id, dout}, {4'd7, 32'h80});
        lsb_valid = 1'b0;
        @(negedge clk_in);

        // I/O byte store stalled by a full buffer for 3 cycles.
        w0 = wlog.size();
        rob_valid = 1'b1; rob_addr = 32'h00030000; rob_data = 32'h41; rob_size = 2'd0;
        io_buffer_full = 1'b1;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            if (byte_wr || wdone) seen++;
        end
        check("io_stall_cycles", seen, 0);
        io_buffer_full = 1'b0;
        #1;
        check("io_write_port", {byte_wr, byte_a, byte_din}, {1'b1, 32'h00030000, 8'h41});
        @(negedge clk_in);
        check("io_wdone", wdone, 1);
        check("io_log", {wlog.size() - w0, wlog[w0]}, {32'd1, 32'h00030000, 8'h41});
        rob_valid = 1'b0;
        @(negedge clk_in);

        // Flush a word load at byte_cnt == 2.
        lsb_valid = 1'b1; lsb_addr = 32'h100; lsb_size = 2'd2; lsb_signed = 1'b0; lsb_rob_id = 4'd1;
        repeat (3) @(negedge clk_in);
        check("clr_precond_addr", byte_a, 32'h102);
        clear_in = 1'b1; lsb_valid = 1'b0;
        @(negedge clk_in);
        clear_in = 1'b0;
        check("clr_idle_addr", byte_a, 0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (dout_ready) seen++;
            @(negedge clk_in);
        end
        check("clr_no_pulse", seen, 0);

        // Flush during a word store: all four bytes still written.
        w0 = wlog.size();
        rob_valid = 1'b1; rob_addr = 32'h220; rob_data = 32'hCAFEF00D; rob_size = 2'd2;
        repeat (2) @(negedge clk_in);
        clear_in = 1'b1;
        repeat (2) @(negedge clk_in);
        clear_in = 1'b0;
        wait_done(20, c);
        check("clrw_wdone", wdone, 1);
        check("clrw_count", wlog.size() - w0, 4);
        check("clrw_b0_b1", {wlog[w0], wlog[w0 + 1]}, {32'h220, 8'h0D, 32'h221, 8'hF0});
        check("clrw_b2_b3", {wlog[w0 + 2], wlog[w0 + 3]}, {32'h222, 8'hFE, 32'h223, 8'hCA});
        rob_valid = 1'b0;
        @(negedge clk_in);

        // Read the stored word back.
        lsb_valid = 1'b1; lsb_addr = 32'h220; lsb_size = 2'd2; lsb_signed = 1'b1; lsb_rob_id = 4'd4;
        wait_done(20, c);
        check("lw_readback", {c[3:0], dout}, {4'd6, 32'hCAFEF00D});
        lsb_valid = 1'b0;
        @(negedge clk_in);

        // Flush in the DONE cycle of a load hides its pulse.
        lsb_valid = 1'b1; lsb_addr = 32'h150; lsb_size = 2'd0; lsb_signed = 1'b1; lsb_rob_id = 4'd2;
        repeat (3) @(negedge clk_in);
        clear_in = 1'b1;
        #1;
        check("clr_done_pulse", dout_ready, 0);
        check("clr_done_tag", dout_rob_id, 4'd2);
        lsb_valid = 1'b0;
        @(negedge clk_in);
        clear_in = 1'b0;
        @(negedge clk_in);

        // rdy_in low freezes a store and blocks the write strobe.
        w0 = wlog.size();
        rob_valid = 1'b1; rob_addr = 32'h230; rob_data = 32'h77; rob_size = 2'd0;
        @(negedge clk_in);
        check("rdy_precond_wr", byte_wr, 1);
        rdy_in = 1'b0;
        #1;
        check("rdy_low_wr", byte_wr, 0);
        repeat (2) @(negedge clk_in);
        check("rdy_hold", {byte_wr, wdone, byte_a}, {2'b00, 32'h230});
        rdy_in = 1'b1;
        wait_done(10, c);
        check("rdy_resume", {c[3:0], wdone}, {4'd1, 1'b1});
        check("rdy_log", {wlog.size() - w0, wlog[w0]}, {32'd1, 32'h230, 8'h77});
        rob_valid = 1'b0;
        @(negedge clk_in);

        // Asynchronous reset in the middle of a word store.
        rob_valid = 1'b1; rob_addr = 32'h240; rob_data = 32'h11223344; rob_size = 2'd2;
        repeat (2) @(negedge clk_in);
        check("rst_precond", {byte_wr, byte_a}, {1'b1, 32'h241});
        rst_n_in = 1'b0;
        #1;
        check("rst_async_port", {byte_wr, byte_a, wdone}, 0);
        check("rst_async_data", iout, 0);
        rob_valid = 1'b0;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (2) @(negedge clk_in);
        check("rst_stays_idle", {byte_wr, byte_a, wdone}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
